// File: rtl/accel_round_gen.sv
// Accelerometer round generator: gathers one x/y/z sample set, publishes it,
// and holds roundDD high for a fixed window so another clock domain can capture.
module accel_round_gen #(
   parameter int unsigned HOLD_CYCLES = 8,
   parameter int unsigned GAP_CYCLES  = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        sample_valid,
   input  logic [1:0]  sample_axis,
   input  logic [11:0] sample_data,
   output logic [11:0] x_acc_reg_temp,
   output logic [11:0] y_acc_reg_temp,
   output logic [11:0] z_acc_reg_temp,
   output logic        roundDD,
   output logic        busy,
   output logic        overrun,
   output logic [7:0]  round_cnt
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_COLLECT,
      S_HOLD,
      S_GAP
   } state_t;

   localparam logic [7:0] HOLD_LD = 8'(HOLD_CYCLES - 1);
   localparam logic [7:0] GAP_LD  = 8'(GAP_CYCLES - 1);

   state_t      state_q;
   logic [2:0]  mask_q, mask_d;
   logic [7:0]  cnt_q;
   logic [11:0] sx_q, sy_q, sz_q;
   logic [11:0] sx_d, sy_d, sz_d;
   logic [11:0] px_q, py_q, pz_q;
   logic        dd_q;
   logic        ovr_q;
   logic [7:0]  rcnt_q;
   logic        hit;
   logic        complete;

   // A strobe on axis 3 is never a real sample.
   always_comb begin
      hit      = sample_valid && (sample_axis != 2'd3);
      mask_d   = mask_q;
      sx_d     = sx_q;
      sy_d     = sy_q;
      sz_d     = sz_q;
      if (hit) begin
         mask_d = mask_q | (3'b001 << sample_axis);
         unique case (1'b1)
            sample_axis == 2'd0: sx_d = sample_data;
            sample_axis == 2'd1: sy_d = sample_data;
            default:             sz_d = sample_data;
         endcase
      end
      complete = &mask_d;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         mask_q  <= 3'b000;
         cnt_q   <= 8'd0;
         sx_q    <= 12'd0;
         sy_q    <= 12'd0;
         sz_q    <= 12'd0;
         px_q    <= 12'd0;
         py_q    <= 12'd0;
         pz_q    <= 12'd0;
         dd_q    <= 1'b0;
         ovr_q   <= 1'b0;
         rcnt_q  <= 8'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q <= S_COLLECT;
                  mask_q  <= 3'b000;
                  ovr_q   <= 1'b0;
                  cnt_q   <= 8'd0;
               end
            end
            S_COLLECT: begin
               if (!start) begin
                  state_q <= S_IDLE;
                  mask_q  <= 3'b000;
                  cnt_q   <= 8'd0;
               end else begin
                  sx_q   <= sx_d;
                  sy_q   <= sy_d;
                  sz_q   <= sz_d;
                  mask_q <= mask_d;
                  if (complete) begin
                     px_q    <= sx_d;
                     py_q    <= sy_d;
                     pz_q    <= sz_d;
                     dd_q    <= 1'b1;
                     rcnt_q  <= rcnt_q + 8'd1;
                     mask_q  <= 3'b000;
                     state_q <= S_HOLD;
                     cnt_q   <= HOLD_LD;
                  end
               end
            end
            S_HOLD: begin
               if (hit) ovr_q <= 1'b1;
               if (cnt_q == 8'd0) begin
                  dd_q    <= 1'b0;
                  state_q <= S_GAP;
                  cnt_q   <= GAP_LD;
               end else begin
                  cnt_q <= cnt_q - 8'd1;
               end
            end
            S_GAP: begin
               if (hit) ovr_q <= 1'b1;
               if (cnt_q == 8'd0) begin
                  state_q <= start ? S_COLLECT : S_IDLE;
                  mask_q  <= 3'b000;
                  cnt_q   <= 8'd0;
               end else begin
                  cnt_q <= cnt_q - 8'd1;
               end
            end
            default: begin
               state_q <= S_IDLE;
               mask_q  <= 3'b000;
               cnt_q   <= 8'd0;
               dd_q    <= 1'b0;
            end
         endcase
      end
   end

   assign x_acc_reg_temp = px_q;
   assign y_acc_reg_temp = py_q;
   assign z_acc_reg_temp = pz_q;
   assign roundDD        = dd_q;
   assign busy           = (state_q != S_IDLE);
   assign overrun        = ovr_q;
   assign round_cnt      = rcnt_q;

endmodule

// File: tb/tb_accel_round_gen.sv
// Scoreboard bench for accel_round_gen: stimulus queues expected rounds,
// a negedge monitor pops them on each roundDD rise and checks timing.
module tb_accel_round_gen;

   localparam int HOLD = 8;
   localparam int GAP  = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        sample_valid = 1'b0;
   logic [1:0]  sample_axis = 2'd0;
   logic [11:0] sample_data = 12'd0;
   logic [11:0] x_acc_reg_temp, y_acc_reg_temp, z_acc_reg_temp;
   logic        roundDD, busy, overrun;
   logic [7:0]  round_cnt;

   accel_round_gen #(
      .HOLD_CYCLES(HOLD),
      .GAP_CYCLES (GAP)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .sample_valid  (sample_valid),
      .sample_axis   (sample_axis),
      .sample_data   (sample_data),
      .x_acc_reg_temp(x_acc_reg_temp),
      .y_acc_reg_temp(y_acc_reg_temp),
      .z_acc_reg_temp(z_acc_reg_temp),
      .roundDD       (roundDD),
      .busy          (busy),
      .overrun       (overrun),
      .round_cnt     (round_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [11:0] x;
      logic [11:0] y;
      logic [11:0] z;
      logic [7:0]  cnt;
      int          rise;
   } exp_t;

   exp_t q[$];
   int checks = 0;
   int failures = 0;
   logic [7:0] rc_model = 8'd0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic strobe(input int ax, input logic [11:0] d);
      sample_valid = 1'b1;
      sample_axis  = ax[1:0];
      sample_data  = d;
      tick(1);
      sample_valid = 1'b0;
      sample_axis  = 2'd0;
      sample_data  = 12'd0;
   endtask

   task automatic push(input logic [11:0] x, input logic [11:0] y,
                       input logic [11:0] z);
      exp_t e;
      rc_model = rc_model + 8'd1;
      e.x = x;
      e.y = y;
      e.z = z;
      e.cnt = rc_model;
      e.rise = cyc + 1;
      q.push_back(e);
   endtask

   task automatic full_round(input logic [11:0] x, input logic [11:0] y,
                             input logic [11:0] z);
      strobe(0, x);
      strobe(1, y);
      push(x, y, z);
      strobe(2, z);
   endtask

   // Monitor: round contents, latency, hold length, gap length, stability.
   logic        prev_dd = 1'b0;
   int          hi = 0;
   int          lo = 0;
   bit          have_fall = 1'b0;
   logic [11:0] lx = 12'd0, ly = 12'd0, lz = 12'd0;

   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         prev_dd   = 1'b0;
         hi        = 0;
         lo        = 0;
         have_fall = 1'b0;
         lx = 12'd0;
         ly = 12'd0;
         lz = 12'd0;
      end else begin
         if (roundDD && !prev_dd) begin
            if (have_fall) chk("gap_len_ok", 64'(lo >= GAP), 64'd1);
            if (q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_round actual=rise required=none");
            end else begin
               e = q.pop_front();
               chk("round_x", x_acc_reg_temp, e.x);
               chk("round_y", y_acc_reg_temp, e.y);
               chk("round_z", z_acc_reg_temp, e.z);
               chk("round_cnt", round_cnt, e.cnt);
               chk("latency", cyc, e.rise);
            end
            lx = x_acc_reg_temp;
            ly = y_acc_reg_temp;
            lz = z_acc_reg_temp;
            hi = 1;
         end else begin
            chk("stable", {x_acc_reg_temp, y_acc_reg_temp, z_acc_reg_temp},
                {lx, ly, lz});
            if (roundDD) begin
               hi++;
            end else if (prev_dd) begin
               chk("hold_len", hi, HOLD);
               have_fall = 1'b1;
               lo = 1;
            end else begin
               lo++;
            end
         end
         prev_dd = roundDD;
      end
   end

   initial begin
      int budget;
      #2 reset = 1'b0;
      tick(2);
      chk("rst_roundDD", roundDD, 0);
      chk("rst_busy", busy, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_round_cnt", round_cnt, 0);
      chk("rst_x", x_acc_reg_temp, 0);
      chk("rst_y", y_acc_reg_temp, 0);
      chk("rst_z", z_acc_reg_temp, 0);
      reset = 1'b1;
      tick(1);

      strobe(0, 12'hFFF);
      tick(1);
      chk("idle_no_overrun", overrun, 0);
      chk("idle_busy", busy, 0);
      start = 1'b1;
      tick(1);
      chk("collect_busy", busy, 1);

      // Strobes on cycles 0, 2, 4.
      strobe(0, 12'h123);
      tick(1);
      strobe(1, 12'h456);
      tick(1);
      push(12'h123, 12'h456, 12'h789);
      strobe(2, 12'h789);
      tick(HOLD + GAP + 1);

      // Last value wins; axis 3 ignored.
      strobe(0, 12'h001);
      strobe(0, 12'h0FF);
      strobe(3, 12'hAAA);
      strobe(1, 12'h0AB);
      push(12'h0FF, 12'h0AB, 12'h0CD);
      strobe(2, 12'h0CD);

      // Dropped sample during HOLD.
      tick(2);
      strobe(2, 12'h555);
      tick(1);
      chk("overrun_set", overrun, 1);
      chk("z_held", z_acc_reg_temp, 12'h0CD);
      tick(HOLD + GAP);
      full_round(12'h111, 12'h222, 12'h333);
      tick(HOLD + GAP + 1);
      chk("overrun_sticky", overrun, 1);

      // start dropped mid-collect.
      strobe(0, 12'h777);
      strobe(1, 12'h888);
      start = 1'b0;
      tick(2);
      chk("abort_busy", busy, 0);
      chk("abort_roundDD", roundDD, 0);
      chk("abort_overrun_kept", overrun, 1);
      chk("abort_x_kept", x_acc_reg_temp, 12'h111);
      chk("abort_y_kept", y_acc_reg_temp, 12'h222);
      start = 1'b1;
      tick(1);
      chk("exit_idle_clr_ovr", overrun, 0);
      chk("exit_idle_busy", busy, 1);
      strobe(2, 12'h999);
      tick(3);
      chk("mask_cleared", roundDD, 0);
      chk("cnt_no_partial", round_cnt, 3);
      strobe(0, 12'h0A1);
      push(12'h0A1, 12'h0A2, 12'h999);
      strobe(1, 12'h0A2);

      // Reset mid-HOLD.
      tick(3);
      reset = 1'b0;
      #1;
      chk("midrst_roundDD", roundDD, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_cnt", round_cnt, 0);
      chk("midrst_xyz", {x_acc_reg_temp, y_acc_reg_temp, z_acc_reg_temp},
          36'd0);
      rc_model = 8'd0;
      tick(2);
      reset = 1'b1;
      tick(1);
      chk("post_rst_busy", busy, 1);
      full_round(12'hBBB, 12'hCCC, 12'hDDD);
      tick(HOLD + GAP + 1);

      // Wrap the round counter.
      for (int k = 0; k < 256; k++) begin
         full_round(12'(k), 12'(k + 256), 12'(k + 512));
         if (rc_model == 8'd0) chk("wrap_zero", round_cnt, 0);
         tick(HOLD + GAP + 1);
      end
      chk("wrap_final", round_cnt, rc_model);

      budget = 50;
      while (q.size() != 0 && budget > 0) begin
         tick(1);
         budget--;
      end
      chk("queue_drained", q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/accel_round_gen.md
ACCEL_ROUND_GEN -- requirements
Module: accel_round_gen

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 8, giving the number of cycles roundDD is held high per round (legal range 4..255).
REQ-002 The block SHALL have parameter GAP_CYCLES, default 4, giving the number of cycles roundDD is held low after a hold before the next round may start (legal range 1..255).
REQ-003 clk  input  1  accelerometer-domain clock; this block uses one clock only.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  level enable; high = run rounds continuously.
REQ-006 sample_valid  input  1  one-cycle strobe; sample_axis/sample_data are valid this cycle.
REQ-007 sample_axis  input  2  0=x, 1=y, 2=z, 3=invalid.
REQ-008 sample_data  input  12  raw 12-bit axis sample.
REQ-009 x_acc_reg_temp, y_acc_reg_temp, z_acc_reg_temp  output  12 each  published round values, registered.
REQ-010 roundDD  output  1  round-done level; while high, all three published values are stable and valid for capture by the other clock domain.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 overrun  output  1  sticky flag; a sample was dropped.
REQ-013 round_cnt  output  8  count of completed rounds, wrapping.

Function
REQ-014 The FSM SHALL have the states IDLE, COLLECT, HOLD and GAP.
REQ-015 IDLE: when start=1 the FSM SHALL go to COLLECT on the next edge with axis mask=000; a sample_valid in IDLE SHALL be ignored and SHALL NOT set overrun.
REQ-016 COLLECT: sample_valid with axis 0/1/2 SHALL write the shadow register for that axis and set its mask bit; a repeated axis SHALL overwrite its shadow (last value wins); axis 3 SHALL be ignored.
REQ-017 COLLECT: when the mask becomes 111 (including a valid sample in the same cycle), on the next edge the block SHALL copy all three shadows to the outputs, set roundDD=1, increment round_cnt, and enter HOLD; latency from the completing strobe to roundDD high SHALL be 1 cycle.
REQ-018 COLLECT with start=0 SHALL return to IDLE and clear the mask; shadows SHALL be left unchanged and the outputs SHALL NOT update.
REQ-019 HOLD SHALL keep roundDD=1 for exactly HOLD_CYCLES cycles; the FSM SHALL then enter GAP with roundDD=0.
REQ-020 GAP SHALL last exactly GAP_CYCLES cycles; the FSM SHALL then go to COLLECT (mask=000) if start=1, otherwise to IDLE.
REQ-021 The published outputs SHALL change only on the REQ-017 transfer edge; they SHALL remain stable through HOLD, GAP, IDLE and the following COLLECT.
REQ-022 sample_valid with axis 0..2 in HOLD or GAP SHALL be dropped (shadow unchanged) and SHALL set overrun=1.
REQ-023 overrun SHALL clear only on reset or on the edge at which the FSM leaves IDLE.
REQ-024 start=0 during HOLD or GAP SHALL NOT shorten either phase.
REQ-025 round_cnt SHALL wrap from 255 to 0 without any other side effect.
REQ-026 The hold/gap counter SHALL be 8 bits wide and SHALL reload on every state entry.

Reset
REQ-027 On reset=0, asynchronously: state=IDLE, mask=000, shadows=0, all published outputs=0, roundDD=0, busy=0, overrun=0, round_cnt=0.
REQ-028 Reset asserted mid-HOLD SHALL drop roundDD immediately; no partial round SHALL be published after release.
REQ-029 After reset release, operation SHALL resume from IDLE on the first edge at which start=1.

Verification
REQ-030 start=1; strobes x=0x123, y=0x456, z=0x789 on cycles 0, 2, 4 -> outputs=0x123/0x456/0x789 and roundDD=1 at cycle 5, high for exactly 8 cycles, then low for 4, round_cnt=1.
REQ-031 In COLLECT, x=0x001 then x=0x0FF, then y, z -> x_acc_reg_temp=0x0FF; axis-3 strobe with data 0xAAA -> no effect.
REQ-032 A strobe z=0x555 during HOLD -> overrun=1, published z unchanged, next round unaffected except for that sample; overrun stays 1 until the next exit from IDLE.
REQ-033 start dropped after x,y only -> IDLE, outputs keep the previous round's values, roundDD stays 0.
REQ-034 reset pulsed low mid-HOLD -> all outputs 0 in the same cycle, roundDD=0, busy=0; after release with start=1, the next full round publishes normally.
REQ-035 Run 256 rounds -> round_cnt wraps to 0; roundDD low time between rounds is never less than GAP_CYCLES.
